// File: rtl/demux_slot_unpacker.sv
// Keyed demultiplexer: collects (key, data) beats into NR_SLOT slots and presents
// the finished frame as one wide word with a slot-filled mask and an error flag.
module demux_slot_unpacker #(
    parameter int NR_SLOT  = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [KEY_LEN-1:0]           in_key,
    input  logic [DATA_LEN-1:0]          in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NR_SLOT*DATA_LEN-1:0]  out_data,
    output logic [NR_SLOT-1:0]           out_mask,
    output logic                         out_err
);

    typedef enum logic {
        COLLECT,
        PRESENT
    } state_t;

    state_t state, state_next;

    logic [NR_SLOT-1:0][DATA_LEN-1:0] slot_q;
    logic [NR_SLOT-1:0]               mask_q;
    logic                             err_q;
    logic [NR_SLOT-1:0]               key_hit;
    logic                             key_bad;
    logic                             key_dup;
    logic                             beat_acc;
    logic                             out_hs;

    // One-hot decode of the key; a key matching no slot is out of range.
    always_comb begin
        key_hit = '0;
        for (int n = 0; n < NR_SLOT; n++) begin
            key_hit[n] = (in_key == KEY_LEN'(n));
        end
        key_bad = ~|key_hit;
        key_dup = |(key_hit & mask_q);
    end

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == PRESENT);
    assign beat_acc  = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (beat_acc && in_last) state_next = PRESENT;
            PRESENT: if (out_ready)           state_next = COLLECT;
            default:                          state_next = COLLECT;
        endcase
    end

    // Slot storage is wiped on the output handshake so unwritten slots of the
    // next frame read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
        end else if (out_hs) begin
            slot_q <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
        end else if (beat_acc) begin
            for (int n = 0; n < NR_SLOT; n++) begin
                if (key_hit[n]) begin
                    slot_q[n] <= in_data;
                end
            end
            mask_q <= mask_q | key_hit;
            if (key_bad || key_dup) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_data = slot_q;
    assign out_mask = mask_q;
    assign out_err  = err_q;

endmodule

// File: tb/tb_demux_slot_unpacker.sv
// Scoreboard bench for demux_slot_unpacker: a 4-slot instance and a 3-slot
// instance (which has an unused key value) run against a frame-level model.
module tb_demux_slot_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_err;
    logic [1:0] a_in_key, a_in_data;
    logic [7:0] a_out_data;
    logic [3:0] a_out_mask;

    logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_err;
    logic [1:0] b_in_key, b_in_data;
    logic [5:0] b_out_data;
    logic [2:0] b_out_mask;

    demux_slot_unpacker #(.NR_SLOT(4), .KEY_LEN(2), .DATA_LEN(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_key(a_in_key),
        .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_mask(a_out_mask), .out_err(a_out_err)
    );

    demux_slot_unpacker #(.NR_SLOT(3), .KEY_LEN(2), .DATA_LEN(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_key(b_in_key),
        .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_mask(b_out_mask), .out_err(b_out_err)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] mask;
        logic       err;
    } frame_t;

    frame_t exp_a[$];
    frame_t exp_b[$];

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;
    bit post_hs_a = 1'b0;
    bit post_hs_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_in(input bit sel, input logic v, input logic [1:0] k,
                          input logic [1:0] d, input logic l);
        if (sel) begin
            b_in_valid = v; b_in_key = k; b_in_data = d; b_in_last = l;
        end else begin
            a_in_valid = v; a_in_key = k; a_in_data = d; a_in_last = l;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? b_in_ready : a_in_ready;
    endfunction

    // Frame model: each beat lands in the slot its key names; a repeated key
    // or a key beyond the slot count marks the frame as errored.
    function automatic frame_t model(input int nr_slot, input int n, input int ka[8], input int da[8]);
        frame_t e = '0;
        for (int i = 0; i < n; i++) begin
            if (ka[i] < nr_slot) begin
                if (e.mask[ka[i]]) e.err = 1'b1;
                e.mask[ka[i]] = 1'b1;
                e.data[2*ka[i] +: 2] = 2'(da[i]);
            end else begin
                e.err = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit sel, input int n, input int ka[8],
                                 input int da[8], input bit gaps);
        frame_t e;
        int t;
        bit ok;
        e = model(sel ? 3 : 4, n, ka, da);
        if (sel) exp_b.push_back(e);
        else     exp_a.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                set_in(sel, 1'b0, 2'd0, 2'd0, 1'b0);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            set_in(sel, 1'b1, 2'(ka[i]), 2'(da[i]), (i == n - 1));
            t = 0;
            ok = 1'b0;
            while (!ok && t < 200) begin
                @(negedge clk);
                if (rdy(sel)) ok = 1'b1;
                t++;
            end
            if (!ok) chk("accept_timeout", {31'b0, ok}, 1);
            @(posedge clk); #1;
            if (i == n - 1) chk("latency_out_valid", sel ? b_out_valid : a_out_valid, 1);
        end
        set_in(sel, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic wait_drain(input bit sel);
        int t = 0;
        while ((sel ? exp_b.size() : exp_a.size()) > 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk(sel ? "drain_b" : "drain_a", sel ? exp_b.size() : exp_a.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: every cycle a frame is presented it must equal the scoreboard head.
    task automatic checkOutput(input bit sel);
        frame_t act;
        logic   v, r, ir;
        v  = sel ? b_out_valid : a_out_valid;
        r  = sel ? b_out_ready : a_out_ready;
        ir = sel ? b_in_ready  : a_in_ready;
        act.data = sel ? {2'b00, b_out_data} : a_out_data;
        act.mask = sel ? {1'b0, b_out_mask} : a_out_mask;
        act.err  = sel ? b_out_err : a_out_err;
        if (sel ? post_hs_b : post_hs_a) begin
            chk("post_hs_in_ready", ir, 1);
            chk("post_hs_out_valid", v, 0);
            if (sel) post_hs_b = 1'b0;
            else     post_hs_a = 1'b0;
        end
        if (v) begin
            if ((sel ? exp_b.size() : exp_a.size()) == 0) begin
                chk(sel ? "unexpected_frame_b" : "unexpected_frame_a", v, 0);
            end else begin
                frame_t e = sel ? exp_b[0] : exp_a[0];
                chk(sel ? "out_data_b" : "out_data_a", act.data, e.data);
                chk(sel ? "out_mask_b" : "out_mask_a", act.mask, e.mask);
                chk(sel ? "out_err_b"  : "out_err_a",  act.err,  e.err);
                if (r) begin
                    if (sel) begin void'(exp_b.pop_front()); post_hs_b = 1'b1; end
                    else     begin void'(exp_a.pop_front()); post_hs_a = 1'b1; end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        checkOutput(1'b0);
        checkOutput(1'b1);
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) begin
                a_out_ready = 1'($urandom_range(0, 1));
                b_out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int ka[8];
        int da[8];
        int n;

        rst = 1'b1;
        set_in(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        set_in(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("reset_out_valid", a_out_valid, 0);
        chk("reset_out_data", a_out_data, 0);
        chk("reset_out_mask", a_out_mask, 0);
        chk("reset_out_err", a_out_err, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", a_in_ready, 1);

        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        ka = '{0, 1, 2, 3, 0, 0, 0, 0}; da = '{1, 2, 3, 0, 0, 0, 0, 0};
        applyStimulus(1'b0, 4, ka, da, 1'b0);
        ka = '{2, 0, 0, 0, 0, 0, 0, 0}; da = '{3, 1, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b0, 2, ka, da, 1'b0);
        ka = '{1, 1, 0, 0, 0, 0, 0, 0}; da = '{1, 2, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b0, 2, ka, da, 1'b0);
        wait_drain(1'b0);

        // Frame held in PRESENT while the source keeps offering beats.
        a_out_ready = 1'b0;
        ka = '{0, 3, 0, 0, 0, 0, 0, 0}; da = '{3, 1, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b0, 2, ka, da, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
            @(negedge clk);
            chk("hold_in_ready", a_in_ready, 0);
            @(posedge clk); #1;
        end
        set_in(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        wait_drain(1'b0);

        ka = '{3, 0, 0, 0, 0, 0, 0, 0}; da = '{3, 2, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b1, 2, ka, da, 1'b0);
        ka = '{3, 0, 0, 0, 0, 0, 0, 0}; da = '{1, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b1, 1, ka, da, 1'b0);
        wait_drain(1'b1);

        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < 8; i++) begin
                ka[i] = $urandom_range(0, 3);
                da[i] = $urandom_range(0, 3);
            end
            applyStimulus(f % 2 == 1, n, ka, da, 1'b1);
        end
        rand_ready = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        wait_drain(1'b0);
        wait_drain(1'b1);

        // Asynchronous reset in the middle of a frame discards it.
        set_in(1'b0, 1'b1, 2'd0, 2'd1, 1'b0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b1, 2'd1, 2'd2, 1'b0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("midframe_reset_out_valid", a_out_valid, 0);
        chk("midframe_reset_mask", a_out_mask, 0);
        chk("midframe_reset_data", a_out_data, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        ka = '{2, 0, 0, 0, 0, 0, 0, 0}; da = '{1, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b0, 1, ka, da, 1'b0);
        wait_drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_slot_unpacker.md
Name: demux_slot_unpacker

Overview:
- Keyed demultiplexer: the inverse of the keyed mux library.
- Accepts a stream of (key, data) beats on a valid/ready input and routes each data word into the output slot its key names.
- The frame is closed on the last beat and presented as one wide word with a slot-filled mask.
- Used to rebuild parallel operand sets (e.g. x0..x3) from a narrow serial source.

Parameters:
- NR_SLOT, 4, number of output slots; keys 0..NR_SLOT-1 are legal.
- KEY_LEN, 2, key width; must satisfy 2**KEY_LEN >= NR_SLOT.
- DATA_LEN, 2, width of one data word / slot.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_key  input  KEY_LEN  destination slot of this beat.
- in_data  input  DATA_LEN  data word of this beat.
- in_last  input  1  this beat closes the frame.
- out_valid  output  1  assembled frame available.
- out_ready  input  1  consumer accepts the frame.
- out_data  output  NR_SLOT*DATA_LEN  slot n at bits [DATA_LEN*(n+1)-1 : DATA_LEN*n].
- out_mask  output  NR_SLOT  bit n = 1 if slot n was written in this frame.
- out_err  output  1  frame saw an out-of-range key or a duplicate key.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to COLLECT.
  - out_valid=0; out_data, out_mask and out_err are all 0.
  - in_ready=1 once rst is released.
  - A partially collected frame is discarded; there is no recovery after reset.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid && in_ready.
  - Accepted beat with in_key < NR_SLOT: slot[in_key] <= in_data and mask[in_key] <= 1.
  - If mask[in_key] was already 1, the later write overwrites the slot and err <= 1.
  - Accepted beat with in_key >= NR_SLOT (possible only when 2**KEY_LEN > NR_SLOT): data dropped, err <= 1, other slots untouched.
  - Accepted beat with in_last=1: that beat's data is stored under the rules above, then state goes to PRESENT next cycle.
  - A frame may contain a single beat, including a single bad-key beat (result: mask=0, err=1).
- State PRESENT:
  - out_valid=1, in_ready=0.
  - out_data, out_mask and out_err hold the collected values, stable until handshake.
  - Unwritten slots read as 0.
  - When out_valid && out_ready: next cycle state is COLLECT, slots/mask/err are cleared to 0, out_valid=0, in_ready=1.
  - No same-cycle bypass: the first beat of the next frame is accepted no earlier than the cycle after the output handshake.
- Latency:
  - The last input beat is accepted on edge k; out_valid=1 from edge k onward, i.e. visible in the cycle after acceptance.
  - Minimum frame period is beats+1 cycles when out_ready is held at 1.
- Protocol rules:
  - in_valid may be asserted while in_ready=0; nothing is accepted, and the source must hold the beat.
  - out_ready may be high while out_valid=0; it has no effect.
  - All outputs are driven from registers or state decode only; no combinational path from in_* to out_*.
- Width rules:
  - Keys compare unsigned at full KEY_LEN.
  - Data is stored unmodified; there is no arithmetic.

Test Plan:
- Reset, then beats (0,2'b01),(1,2'b10),(2,2'b11),(3,2'b00,last), out_ready=1 -> out_valid one cycle after last accept; out_data=8'b00_11_10_01, mask=4'b1111, err=0; in_ready=1 the cycle after handshake.
- Beats (2,2'b11),(0,2'b01,last) -> out_data=8'b00_11_00_01, mask=4'b0101, err=0.
- Beats (1,2'b01),(1,2'b10,last) -> slot1=2'b10, mask=4'b0010, err=1.
- out_ready=0 for 5 cycles while in PRESENT, with in_valid=1 toggling in_data -> in_ready=0 throughout; out_* stable; no beat absorbed; frame released on the out_ready pulse.
- NR_SLOT=3, KEY_LEN=2: beats (3,2'b11),(0,2'b10,last) -> out_data=6'b00_00_10, mask=3'b001, err=1.
- Assert rst low asynchronously after 2 beats of a frame -> out_valid=0, mask=0 immediately; after release, a fresh 1-beat frame (2,2'b01,last) gives mask=4'b0100 with no stale data.
